// File: rtl/reg_scoreboard.sv
// Per-register in-flight writer scoreboard for the decode stage: produces the issue stall,
// the per-source forwarding flags and a sticky protocol-error flag.
module reg_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ds_valid,
  input  logic [4:0] ds_rj,
  input  logic       ds_rj_used,
  input  logic [4:0] ds_rkd,
  input  logic       ds_rkd_used,
  input  logic       ds_gr_we,
  input  logic [4:0] ds_dest,
  input  logic       ds_is_load,
  input  logic       ds_issue,
  input  logic       es_load_adv,
  input  logic [4:0] es_load_dest,
  input  logic       ws_retire,
  input  logic [4:0] ws_dest,
  input  logic       flush,
  output logic       ds_stall,
  output logic       rj_fwd,
  output logic       rkd_fwd,
  output logic       sb_err
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]            lpend_q, lpend_d;
  logic                       sb_err_q, sb_err_d;

  logic            iss;
  logic [NREG-1:0] inc_vec, dec_vec, set_vec, clr_vec;

  logic rj_busy, rkd_busy, rj_lpend, rkd_lpend;
  logic dest_full, dest_lpend;
  logic ws_cnt_zero, adv_no_load;
  logic stall_a, stall_b, stall_c, stall_d;

  assign iss = ds_issue & ds_gr_we & (ds_dest != 5'd0);

  // Entry 0 is never visited, so r0 always reads as idle and never flags an error.
  always_comb begin
    rj_busy     = 1'b0;
    rkd_busy    = 1'b0;
    rj_lpend    = 1'b0;
    rkd_lpend   = 1'b0;
    dest_full   = 1'b0;
    dest_lpend  = 1'b0;
    ws_cnt_zero = 1'b0;
    adv_no_load = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (ds_rj == 5'(r)) begin
        rj_busy  = (cnt_q[r] != '0);
        rj_lpend = lpend_q[r];
      end
      if (ds_rkd == 5'(r)) begin
        rkd_busy  = (cnt_q[r] != '0);
        rkd_lpend = lpend_q[r];
      end
      if (ds_dest == 5'(r)) begin
        dest_full  = (cnt_q[r] == CntMax);
        dest_lpend = lpend_q[r];
      end
      if (ws_dest == 5'(r)) begin
        ws_cnt_zero = (cnt_q[r] == '0);
      end
      if (es_load_dest == 5'(r)) begin
        adv_no_load = ~lpend_q[r];
      end
    end
  end

  assign stall_a = ds_rj_used & rj_lpend;
  assign stall_b = ds_rkd_used & rkd_lpend;
  assign stall_c = ds_gr_we & (ds_dest != 5'd0) & dest_full;
  assign stall_d = ds_gr_we & ds_is_load & dest_lpend;

  assign ds_stall = ds_valid & (stall_a | stall_b | stall_c | stall_d);
  assign rj_fwd   = ds_rj_used & rj_busy;
  assign rkd_fwd  = ds_rkd_used & rkd_busy;
  assign sb_err   = sb_err_q;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    set_vec = '0;
    clr_vec = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      inc_vec[r] = iss & (ds_dest == 5'(r));
      dec_vec[r] = ws_retire & (ws_dest == 5'(r));
      set_vec[r] = iss & ds_is_load & (ds_dest == 5'(r));
      clr_vec[r] = es_load_adv & (es_load_dest == 5'(r));
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    lpend_d = lpend_q;
    if (flush) begin
      cnt_d   = '0;
      lpend_d = '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        // Counter saturates at max and floors at zero; simultaneous inc/dec cancel.
        if (inc_vec[r] && !dec_vec[r] && (cnt_q[r] != CntMax)) begin
          cnt_d[r] = cnt_q[r] + CntOne;
        end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - CntOne;
        end
        // A newly issued load is younger than the one leaving EX, so set wins.
        if (set_vec[r]) begin
          lpend_d[r] = 1'b1;
        end else if (clr_vec[r]) begin
          lpend_d[r] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    sb_err_d = sb_err_q;
    if (!flush) begin
      sb_err_d = sb_err_q | (ws_retire & ws_cnt_zero) | (es_load_adv & adv_no_load) |
                 (ds_issue & ds_stall);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      lpend_q  <= '0;
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lpend_q  <= lpend_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, corner-case sequences, then random
// legal traffic checked against an array-based reference model.
module tb_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = 2 ** CNT_W - 1;

  typedef struct packed {
    logic       valid;
    logic [4:0] rj;
    logic       rj_used;
    logic [4:0] rkd;
    logic       rkd_used;
    logic       gr_we;
    logic [4:0] dest;
    logic       is_load;
    logic       issue;
    logic       adv;
    logic [4:0] adv_dest;
    logic       retire;
    logic [4:0] wdest;
    logic       flush;
    logic       e_stall;
    logic       e_rj;
    logic       e_rkd;
    logic       e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ds_valid, ds_rj_used, ds_rkd_used, ds_gr_we, ds_is_load, ds_issue;
  logic [4:0] ds_rj, ds_rkd, ds_dest, es_load_dest, ws_dest;
  logic       es_load_adv, ws_retire, flush;
  logic       ds_stall, rj_fwd, rkd_fwd, sb_err;

  int errors = 0;
  int checks = 0;

  int mcnt[32];
  bit mlp[32];
  bit merr;

  vec_t tbl[$];

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(32), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ds_valid     (ds_valid),
    .ds_rj        (ds_rj),
    .ds_rj_used   (ds_rj_used),
    .ds_rkd       (ds_rkd),
    .ds_rkd_used  (ds_rkd_used),
    .ds_gr_we     (ds_gr_we),
    .ds_dest      (ds_dest),
    .ds_is_load   (ds_is_load),
    .ds_issue     (ds_issue),
    .es_load_adv  (es_load_adv),
    .es_load_dest (es_load_dest),
    .ws_retire    (ws_retire),
    .ws_dest      (ws_dest),
    .flush        (flush),
    .ds_stall     (ds_stall),
    .rj_fwd       (rj_fwd),
    .rkd_fwd      (rkd_fwd),
    .sb_err       (sb_err)
  );

  function automatic vec_t nop();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t ins(int dest, bit ld, int rj, bit rju, int rkd, bit rkdu, bit iss);
    vec_t v;
    v = '0;
    v.valid    = 1'b1;
    v.gr_we    = 1'b1;
    v.dest     = 5'(dest);
    v.is_load  = ld;
    v.rj       = 5'(rj);
    v.rj_used  = rju;
    v.rkd      = 5'(rkd);
    v.rkd_used = rkdu;
    v.issue    = iss;
    return v;
  endfunction

  function automatic vec_t rd(int rj);
    vec_t v;
    v = '0;
    v.valid   = 1'b1;
    v.rj      = 5'(rj);
    v.rj_used = 1'b1;
    return v;
  endfunction

  function automatic vec_t ret(vec_t vi, int w);
    vec_t v;
    v = vi;
    v.retire = 1'b1;
    v.wdest  = 5'(w);
    return v;
  endfunction

  function automatic vec_t adv(vec_t vi, int d);
    vec_t v;
    v = vi;
    v.adv      = 1'b1;
    v.adv_dest = 5'(d);
    return v;
  endfunction

  function automatic vec_t fl(vec_t vi);
    vec_t v;
    v = vi;
    v.flush = 1'b1;
    return v;
  endfunction

  function automatic vec_t ex(vec_t vi, bit st, bit f1, bit f2, bit er);
    vec_t v;
    v = vi;
    v.e_stall = st;
    v.e_rj    = f1;
    v.e_rkd   = f2;
    v.e_err   = er;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ds_valid     = v.valid;
    ds_rj        = v.rj;
    ds_rj_used   = v.rj_used;
    ds_rkd       = v.rkd;
    ds_rkd_used  = v.rkd_used;
    ds_gr_we     = v.gr_we;
    ds_dest      = v.dest;
    ds_is_load   = v.is_load;
    ds_issue     = v.issue;
    es_load_adv  = v.adv;
    es_load_dest = v.adv_dest;
    ws_retire    = v.retire;
    ws_dest      = v.wdest;
    flush        = v.flush;
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input bit st, input bit f1, input bit f2,
                         input bit er);
    chk({tag, ".ds_stall"}, ds_stall, st);
    chk({tag, ".rj_fwd"}, rj_fwd, f1);
    chk({tag, ".rkd_fwd"}, rkd_fwd, f2);
    chk({tag, ".sb_err"}, sb_err, er);
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    chk_all(tag, v.e_stall, v.e_rj, v.e_rkd, v.e_err);
  endtask

  // Reset while decode presents a live reader/writer: outputs must still be idle.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    drive(ins(5, 1, 5, 1, 5, 1, 1));
    @(negedge clk);
    #1;
    chk_all(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(nop());
    for (int i = 0; i < 32; i++) begin
      mcnt[i] = 0;
      mlp[i]  = 1'b0;
    end
    merr = 1'b0;
  endtask

  function automatic bit m_stall(vec_t v);
    return v.valid && ((v.rj_used && mlp[v.rj]) || (v.rkd_used && mlp[v.rkd]) ||
                       (v.gr_we && v.dest != 0 && mcnt[v.dest] == MAXC) ||
                       (v.gr_we && v.is_load && mlp[v.dest]));
  endfunction

  task automatic m_update(input vec_t v);
    bit iss;
    int d, w;
    if (v.flush) begin
      for (int i = 0; i < 32; i++) begin
        mcnt[i] = 0;
        mlp[i]  = 1'b0;
      end
      return;
    end
    iss = v.issue && v.gr_we && v.dest != 0;
    d   = int'(v.dest);
    w   = int'(v.wdest);
    if (v.issue && m_stall(v)) merr = 1'b1;
    if (v.retire && w != 0 && mcnt[w] == 0) merr = 1'b1;
    if (v.adv && v.adv_dest != 0 && !mlp[v.adv_dest]) merr = 1'b1;
    if (!(iss && v.retire && d == w)) begin
      if (iss && mcnt[d] < MAXC) mcnt[d] = mcnt[d] + 1;
      if (v.retire && w != 0 && mcnt[w] > 0) mcnt[w] = mcnt[w] - 1;
    end
    if (v.adv && v.adv_dest != 0) mlp[v.adv_dest] = 1'b0;
    if (iss && v.is_load) mlp[d] = 1'b1;
  endtask

  function automatic int pick();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) :
                                         int'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b1;
    drive(nop());

    // Producer/consumer forwarding window on r5.
    tbl.push_back(ex(ins(5, 0, 5, 1, 0, 0, 1), 0, 0, 0, 0));
    tbl.push_back(ex(rd(5), 0, 1, 0, 0));
    tbl.push_back(ex(rd(5), 0, 1, 0, 0));
    tbl.push_back(ex(ret(rd(5), 5), 0, 1, 0, 0));
    tbl.push_back(ex(rd(5), 0, 0, 0, 0));
    // Load-use on r7: one stall cycle, then forward from MS.
    tbl.push_back(ex(ins(7, 1, 0, 0, 0, 0, 1), 0, 0, 0, 0));
    tbl.push_back(ex(adv(ins(8, 0, 7, 1, 9, 1, 0), 7), 1, 1, 0, 0));
    tbl.push_back(ex(ins(8, 0, 7, 1, 9, 1, 1), 0, 1, 0, 0));
    tbl.push_back(ex(ret(rd(8), 7), 0, 1, 0, 0));
    tbl.push_back(ex(ret(rd(7), 8), 0, 0, 0, 0));
    tbl.push_back(ex(rd(8), 0, 0, 0, 0));
    // Counter saturation on r3.
    tbl.push_back(ex(ins(3, 0, 0, 0, 3, 1, 1), 0, 0, 0, 0));
    tbl.push_back(ex(ins(3, 0, 0, 0, 3, 1, 1), 0, 0, 1, 0));
    tbl.push_back(ex(ins(3, 0, 0, 0, 3, 1, 1), 0, 0, 1, 0));
    tbl.push_back(ex(ret(ins(3, 0, 0, 0, 3, 1, 0), 3), 1, 0, 1, 0));
    tbl.push_back(ex(ins(3, 0, 0, 0, 3, 1, 1), 0, 0, 1, 0));
    tbl.push_back(ex(ins(3, 0, 0, 0, 3, 1, 0), 1, 0, 1, 0));
    tbl.push_back(ex(ret(nop(), 3), 0, 0, 0, 0));
    tbl.push_back(ex(ret(nop(), 3), 0, 0, 0, 0));
    tbl.push_back(ex(ret(nop(), 3), 0, 0, 0, 0));
    tbl.push_back(ex(ins(3, 0, 3, 1, 0, 0, 0), 0, 0, 0, 0));
    // Simultaneous issue and retire on r4 leaves the count at 1.
    tbl.push_back(ex(ins(4, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0));
    tbl.push_back(ex(ret(ins(4, 0, 4, 1, 0, 0, 1), 4), 0, 1, 0, 0));
    tbl.push_back(ex(ret(rd(4), 4), 0, 1, 0, 0));
    tbl.push_back(ex(rd(4), 0, 0, 0, 0));
    // r0 is never tracked.
    tbl.push_back(ex(ins(0, 1, 0, 1, 0, 1, 1), 0, 0, 0, 0));
    tbl.push_back(ex(ret(ins(0, 1, 0, 1, 0, 1, 0), 0), 0, 0, 0, 0));
    tbl.push_back(ex(nop(), 0, 0, 0, 0));

    do_reset("reset0");
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Load to r4 issued over a load-after-load stall while the older load advances.
    do_reset("reset1");
    step(ex(ins(4, 1, 0, 0, 0, 0, 1), 0, 0, 0, 0), "sw0");
    step(ex(adv(ins(4, 1, 4, 1, 0, 0, 1), 4), 1, 1, 0, 0), "sw1");
    step(ex(rd(4), 1, 1, 0, 1), "sw2");
    step(ex(ret(adv(rd(4), 4), 4), 1, 1, 0, 1), "sw3");
    step(ex(ret(rd(4), 4), 0, 1, 0, 1), "sw4");
    step(ex(rd(4), 0, 0, 0, 1), "sw5");

    // Flush with cnt[6]=2, lpend[6]=1, then a stray retire raises the sticky error.
    do_reset("reset2");
    step(ex(ins(6, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0), "fl0");
    step(ex(ins(6, 1, 6, 1, 0, 0, 1), 0, 1, 0, 0), "fl1");
    step(ex(fl(ins(6, 1, 6, 1, 0, 0, 0)), 1, 1, 0, 0), "fl2");
    step(ex(ins(6, 1, 6, 1, 0, 0, 0), 0, 0, 0, 0), "fl3");
    step(ex(ret(nop(), 6), 0, 0, 0, 0), "fl4");
    step(ex(nop(), 0, 0, 0, 1), "fl5");
    step(ex(fl(nop()), 0, 0, 0, 1), "fl6");
    step(ex(nop(), 0, 0, 0, 1), "fl7");
    do_reset("reset3");
    step(ex(nop(), 0, 0, 0, 0), "fl8");
    step(ex(adv(nop(), 9), 0, 0, 0, 0), "ad0");
    step(ex(nop(), 0, 0, 0, 1), "ad1");

    // Random legal traffic against the reference model.
    do_reset("reset4");
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      int s, idx;
      v = '0;
      v.valid    = ($urandom_range(0, 3) != 0);
      v.rj       = 5'(pick());
      v.rj_used  = 1'($urandom_range(0, 1));
      v.rkd      = 5'(pick());
      v.rkd_used = 1'($urandom_range(0, 1));
      v.gr_we    = ($urandom_range(0, 3) != 0);
      v.dest     = 5'(pick());
      v.is_load  = v.gr_we && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) begin
        s = int'($urandom_range(0, 31));
        for (int k = 0; k < 32; k++) begin
          idx = (s + k) % 32;
          if (!v.retire && idx != 0 && mcnt[idx] > 0) begin
            v.retire = 1'b1;
            v.wdest  = 5'(idx);
          end
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        s = int'($urandom_range(0, 31));
        for (int k = 0; k < 32; k++) begin
          idx = (s + k) % 32;
          if (!v.adv && idx != 0 && mlp[idx]) begin
            v.adv      = 1'b1;
            v.adv_dest = 5'(idx);
          end
        end
      end
      v.issue = v.valid && !m_stall(v) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) begin
        v.flush  = 1'b1;
        v.issue  = 1'b0;
        v.retire = 1'b0;
        v.adv    = 1'b0;
      end
      @(negedge clk);
      drive(v);
      #1;
      chk_all($sformatf("rnd%0d", n), m_stall(v), v.rj_used && mcnt[v.rj] != 0,
              v.rkd_used && mcnt[v.rkd] != 0, merr);
      m_update(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register scoreboard and issue-stall controller for the decode stage. It tracks, per architectural register, how many in-flight instructions (EX/MS/WS) will write it, and whether a load to it is still in EX. From this it produces the decode stall and the per-source "forward needed" flags. The decode stage uses those flags to gate `ds_ready_go` and to select the forwarding mux. Issue is counted on the ID→EX handshake and retire on the WB register-file write.

## Interface
Parameters:
- `NREG`, 32: architectural registers; r0 is never tracked.
- `CNT_W`, 2: per-register in-flight counter width; the maximum count is 2^CNT_W−1 (3).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; one clock domain.
- `ds_valid`  in  1  decode holds a valid instruction.
- `ds_rj`  in  5  source 1 index.
- `ds_rj_used`  in  1  instruction reads rj.
- `ds_rkd`  in  5  source 2 index (rk or rd).
- `ds_rkd_used`  in  1  instruction reads rk/rd.
- `ds_gr_we`  in  1  instruction writes a GPR.
- `ds_dest`  in  5  destination index.
- `ds_is_load`  in  1  instruction is a load.
- `ds_issue`  in  1  ID→EX handshake this cycle (`ds_to_es_valid & es_allowin`).
- `es_load_adv`  in  1  a load leaves EX for MS this cycle.
- `es_load_dest`  in  5  dest of that load.
- `ws_retire`  in  1  WB writes the regfile this cycle.
- `ws_dest`  in  5  WB write index.
- `flush`  in  1  discard all in-flight tracking.
- `ds_stall`  out  1  decode must not issue.
- `rj_fwd`  out  1  rj has an in-flight writer (use forwarded value).
- `rkd_fwd`  out  1  rkd has an in-flight writer.
- `sb_err`  out  1  sticky protocol-error flag.

## Operation
- State: `cnt[1..31]` (CNT_W bits each) and `lpend[1..31]` (1 bit each). Index 0 always reads as cnt=0, lpend=0, and writes to it are ignored.
- Effective issue: `iss = ds_issue & ds_gr_we & (ds_dest != 0)`.
- Counter update per register r, at the edge:
  - +1 if `iss` and `ds_dest == r`.
  - −1 if `ws_retire` and `ws_dest == r`.
  - Both at once: unchanged.
- lpend update per register r, at the edge:
  - Set if `iss & ds_is_load` and `ds_dest == r`.
  - Cleared if `es_load_adv` and `es_load_dest == r`.
  - Set and clear for the same r at once: set wins, because the new load is younger.
- `rj_fwd = ds_rj_used & (cnt[ds_rj] != 0)`; `rkd_fwd` is analogous.
- `ds_stall = ds_valid & (A | B | C | D)`, where:
  - A = `ds_rj_used & lpend[ds_rj]`: load-use on rj.
  - B = `ds_rkd_used & lpend[ds_rkd]`: load-use on rkd.
  - C = `ds_gr_we & ds_dest != 0 & cnt[ds_dest] == max`: counter full.
  - D = `ds_gr_we & ds_is_load & lpend[ds_dest]`: load-after-load to the same dest while the first is still in EX.
- `flush` (synchronous) clears every `cnt` and `lpend` at the edge. Issue and retire in the flush cycle are discarded. `sb_err` is not affected.
- `sb_err` sets and stays set until reset when any of these occurs:
  - Retire to a register whose cnt is 0 (the counter stays at 0; no underflow).
  - `ds_issue & ds_stall` in the same cycle (the issue is still counted).
  - `es_load_adv` to a register whose lpend is 0.

## Timing
- Reset: all `cnt`/`lpend` = 0 and `sb_err` = 0, so `ds_stall`, `rj_fwd` and `rkd_fwd` are 0 regardless of other inputs.
- All outputs are combinational from registered state plus the current ds_* inputs. There is no same-cycle bypass of retire or load-advance into the outputs; state changes are visible in the cycle after the edge.
- Load-use penalty is exactly 1 cycle:
  - Load issues at the end of cycle N−1 and sits in EX during cycle N.
  - The dependent instruction in ID is stalled in cycle N.
  - `es_load_adv` at the end of cycle N clears lpend, so the dependent issues in cycle N+1 with `*_fwd = 1` (forwarded from MS).
- An ALU producer never stalls its consumer: from the cycle after issue, `*_fwd = 1` until its retire edge.
- Counter at max: issue to that dest is blocked until a retire. Retire and stall-release occur at the same edge; the blocked instruction issues the following cycle.

## Test plan
- Reset with `ds_valid=1`, rj=5 used: all outputs 0. After issuing add r5, the next cycle shows `rj_fwd=1` for rj=5. After `ws_retire` r5 three cycles later, `rj_fwd=0` the following cycle.
- Load-use: issue ld.w r7, then put add r8,r7,r9 in ID. Expect `ds_stall=1` for exactly 1 cycle. With `es_load_adv` r7 at that edge, the next cycle shows `ds_stall=0` and `rj_fwd=1`.
- Saturation: issue three writes to r3 with no retire, so cnt[3]=3. A fourth writer to r3 gives `ds_stall=1`. After `ws_retire` r3, the stall drops the next cycle and cnt[3] returns to 3 after that issue.
- Simultaneous issue and retire on r4 with cnt=1: cnt[4] stays 1, and issue of ld r4 with `es_load_adv` r4 in the same cycle leaves lpend[4]=1.
- r0: issue writer with dest=0 and read rj=0: `rj_fwd=0` and `ds_stall=0` always. A retire to 0 does not set `sb_err`.
- Flush with cnt[6]=2 and lpend[6]=1: both are 0 the next cycle. Then `ws_retire` r6 sets `sb_err=1`, which stays set until reset.
